word_byte_serializer: RTL and testbench

//  Downstream stage of the 16-bit word producer (top_level, __out0 stream).

---
 rtl/word_byte_serializer.sv | 165 ++++++++++++++++
 tb/tb_word_byte_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_byte_serializer.sv
// Buffers 16-bit words in a FIFO and emits them high byte first as a framed byte stream.
// Optional trailing frame checksum byte: define WORD_BYTE_SERIALIZER_CHECKSUM_EN.
module word_byte_serializer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FRAME_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [15:0]                  in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned FW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
        LO   = 2'd2,
        CSUM = 2'd3
`else
        LO   = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [15:0]     word_q, word_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            valid_d, last_d;
    logic [7:0]      data_d;
    logic [LW-1:0]   count_d;
    logic            push, pop, load_next, xfer, empty, frame_end;
    logic [15:0]     head;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign empty     = (fifo_level == LW'(0));
    assign head      = mem[rd_ptr];
    assign frame_end = (frame_q == FW'(FRAME_WORDS - 1));

    // Next-state and output-register values of the byte sequencer
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_next = 1'b0;
        word_d    = word_q;
        valid_d   = out_valid;
        data_d    = out_data;
        last_d    = out_last;
        frame_d   = frame_q;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: load_next = 1'b1;
            HI: if (xfer) begin
                state_d = LO;
                data_d  = word_q[7:0];
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ word_q[15:8];
`else
                last_d  = frame_end;
`endif
            end
            LO: if (xfer) begin
                frame_d = frame_end ? FW'(0) : frame_q + FW'(1);
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
                csum_d  = csum_q ^ word_q[7:0];
                if (frame_end) begin
                    state_d = CSUM;
                    data_d  = csum_q ^ word_q[7:0];
                    last_d  = 1'b1;
                end else begin
                    load_next = 1'b1;
                end
`else
                load_next = 1'b1;
`endif
            end
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
            CSUM: if (xfer) begin
                csum_d    = 8'h00;
                load_next = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Fetch the next word directly so LO->HI streams without a bubble
        if (load_next) begin
            if (!empty) begin
                pop     = 1'b1;
                word_d  = head;
                data_d  = head[15:8];
                last_d  = 1'b0;
                valid_d = 1'b1;
                state_d = HI;
            end else begin
                last_d  = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = fifo_level + LW'(1);
            2'b01:   count_d = fifo_level - LW'(1);
            default: count_d = fifo_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_q     <= 16'h0000;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_last   <= 1'b0;
            frame_q    <= FW'(0);
            wr_ptr     <= AW'(0);
            rd_ptr     <= AW'(0);
            fifo_level <= LW'(0);
            in_ready   <= 1'b0;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            out_valid  <= valid_d;
            out_data   <= data_d;
            out_last   <= last_d;
            frame_q    <= frame_d;
            fifo_level <= count_d;
            in_ready   <= (count_d != LW'(DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Storage array; contents are don't-care after reset since pointers restart
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench for word_byte_serializer: a frame-level byte model fills an
// expectation queue on every accepted word; a negedge monitor checks each delivered byte.
module tb_word_byte_serializer;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned FRAME_WORDS = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic [15:0]                in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [7:0]                 out_data;
    logic                       out_last;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    int         wcnt = 0;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
    logic [7:0] mcsum = 8'h00;
`endif
    logic       stall_pending = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;

    word_byte_serializer #(.DEPTH(DEPTH), .FRAME_WORDS(FRAME_WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each word yields hi, lo bytes; frame boundary every FRAME_WORDS words
    task automatic model_word(input logic [15:0] w);
        logic fin;
        wcnt++;
        fin = (wcnt == FRAME_WORDS);
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b0, w[7:0]});
        mcsum = mcsum ^ w[15:8] ^ w[7:0];
        if (fin) begin
            exp_q.push_back({1'b1, mcsum});
            mcsum = 8'h00;
        end
`else
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({fin, w[7:0]});
`endif
        if (fin) wcnt = 0;
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            exp_q.delete();
            wcnt = 0;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
            mcsum = 8'h00;
`endif
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, stall_data);
                chk("stall_last", out_last, stall_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {out_last, out_data}, 9'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", out_data, e[7:0]);
                    chk("byte_last", out_last, e[8]);
                end
            end
            stall_pending = out_valid && !out_ready;
            stall_data    = out_data;
            stall_last    = out_last;
            if (in_valid && in_ready) model_word(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        step();
        rst       = 1'b1;
        step();
    endtask

    task automatic push_word(input logic [15:0] w);
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                acc = 1'b1;
                step();
                break;
            end
            step();
        end
        chk("push_accept", acc, 1'b1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            step();
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    logic [15:0] t2w [5] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99aa};

    initial begin
        int bubbles, last_cnt, last_idx, nb, k;
        logic [7:0] last_byte;

        rst = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b1;
        step();
        chk("in_ready_after_rst", in_ready, 1'b1);

        // Single word latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'habcd;
        step();
        in_valid  = 1'b0;
        chk("t1_valid_t1", out_valid, 1'b0);
        chk("t1_level", fifo_level, 1);
        step();
        chk("t1_valid_t2", out_valid, 1'b1);
        chk("t1_hi", out_data, 8'hab);
        step();
        chk("t1_lo", out_data, 8'hcd);
        step();
        chk("t1_idle", out_valid, 1'b0);
        chk("t1_level_end", fifo_level, 0);

        // Fill with consumer stalled
        reset_dut();
        for (int i = 0; i < 5; i++) push_word(t2w[i]);
        in_valid = 1'b0;
        chk("t2_in_ready", in_ready, 1'b0);
        chk("t2_level", fifo_level, 4);
        chk("t2_hold_hi", out_data, 8'h11);
        step(); step(); step();
        chk("t2_hold_hi_later", out_data, 8'h11);
        drain("t2_drain");

        // Continuous stream, no bubbles
        reset_dut();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) push_word(16'($urandom));
                in_valid = 1'b0;
            end
            begin
                k = 0;
                while (!out_valid && k < 20) begin step(); k++; end
                chk("t3_start", out_valid, 1'b1);
                bubbles = 0;
                for (int j = 0; j < 32; j++) begin
                    if (!out_valid) bubbles++;
                    step();
                end
                chk("t3_bubbles", bubbles, 0);
                chk("t3_idle_after", out_valid, 1'b0);
            end
        join
        drain("t3_drain");

        // Frame marker on words 1..8
        reset_dut();
        out_ready = 1'b1;
`ifdef WORD_BYTE_SERIALIZER_CHECKSUM_EN
        nb = 2 * FRAME_WORDS + 1;
`else
        nb = 2 * FRAME_WORDS;
`endif
        last_cnt = 0; last_idx = -1; last_byte = 8'h00;
        fork
            begin
                for (int i = 1; i <= 8; i++) push_word(16'(i));
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < nb; j++) begin
                    k = 0;
                    while (!out_valid && k < 30) begin step(); k++; end
                    chk("t4_byte_present", out_valid, 1'b1);
                    if (!out_valid) break;
                    if (out_last) begin
                        last_cnt++;
                        last_idx  = j;
                        last_byte = out_data;
                    end
                    step();
                end
            end
        join
        chk("t4_last_count", last_cnt, 1);
        chk("t4_last_idx", last_idx, nb - 1);
        chk("t4_last_byte", last_byte, 8'h08);
        drain("t4_drain");

        // Random backpressure and sparse input
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain("t5_drain");

        // Mid-frame reset with buffered words
        reset_dut();
        out_ready = 1'b1;
        push_word(16'h0a0b);
        push_word(16'h0c0d);
        drain("t6_pre_drain");
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'hf000 + 16'(i));
        in_valid = 1'b0;
        chk("t6_level_pre", fifo_level, 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_valid_rst", out_valid, 1'b0);
        chk("t6_level_rst", fifo_level, 0);
        chk("t6_in_ready_rst", in_ready, 1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(16'($urandom));
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
